// File: rtl/filter_pkg.sv
// ---------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the sample-pipeline filter stages.
//   DEF_WIDTH / DEF_FACTOR : default sample width and up/down-sampling ratio
//   sample_t               : default-width unsigned sample
//   lerp_div()             : truncated linear interpolation between two
//                            samples at weight k/FACTOR (default widths)
// ---------------------------------------------------------------------------
package filter_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_FACTOR = 4;
    localparam int DEF_LOG2F  = $clog2(DEF_FACTOR);

    typedef logic [DEF_WIDTH-1:0] sample_t;

    // (prev*(FACTOR-k) + cur*k) >> LOG2F, floor. The weighted sum never
    // exceeds (2^WIDTH-1)*FACTOR, so WIDTH+LOG2F bits hold it exactly.
    function automatic sample_t lerp_div(
        input sample_t                prev,
        input sample_t                cur,
        input logic [DEF_LOG2F:0]     k
    );
        logic [DEF_LOG2F:0]           wprev_v;
        logic [DEF_WIDTH+DEF_LOG2F-1:0] sum_v;
        wprev_v = (DEF_LOG2F+1)'(DEF_FACTOR) - k;
        sum_v   = (DEF_WIDTH+DEF_LOG2F)'(prev) * (DEF_WIDTH+DEF_LOG2F)'(wprev_v)
                + (DEF_WIDTH+DEF_LOG2F)'(cur)  * (DEF_WIDTH+DEF_LOG2F)'(k);
        return DEF_WIDTH'(sum_v >> DEF_LOG2F);
    endfunction

endpackage

// File: rtl/interp_lerp.sv
// ---------------------------------------------------------------------------
// interp_lerp
// Combinational weighted sum and shift for the interpolating upsampler.
//   prev_s : previous input sample
//   cur_s  : current input sample
//   k_s    : output index 1..FACTOR (weight of cur_s in FACTOR-ths)
//   lerp_s : floor((prev_s*(FACTOR-k_s) + cur_s*k_s) / FACTOR)
// ---------------------------------------------------------------------------
module interp_lerp
    import filter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FACTOR = DEF_FACTOR,
    parameter int LOG2F  = $clog2(FACTOR)
) (
    input  logic [WIDTH-1:0] prev_s,
    input  logic [WIDTH-1:0] cur_s,
    input  logic [LOG2F:0]   k_s,
    output logic [WIDTH-1:0] lerp_s
);

    // Intermediate is exactly wide enough: max sum is (2^WIDTH-1)*FACTOR.
    localparam int IW = WIDTH + LOG2F;

    logic [LOG2F:0] wprev_s;
    logic [IW-1:0]  sum_s;

    // Weighted sum of the two samples followed by the divide-by-FACTOR shift.
    always_comb begin
        wprev_s = (LOG2F+1)'(FACTOR) - k_s;
        sum_s   = IW'(prev_s) * IW'(wprev_s) + IW'(cur_s) * IW'(k_s);
        lerp_s  = WIDTH'(sum_s >> LOG2F);
    end

endmodule

// File: rtl/interp_stage.sv
// ---------------------------------------------------------------------------
// interp_stage
// Linear-interpolating upsampler. Each accepted input sample produces FACTOR
// output samples stepping linearly from the previous input to this one; the
// last of them equals the new input exactly.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   data_in   : input sample (unsigned)
//   valid_in  : data_in valid
//   ready_in  : stage accepts data_in this cycle (no path from valid_in)
//   data_out  : interpolated sample (registered)
//   valid_out : data_out valid (registered)
//   ready_out : downstream accepts data_out
// ---------------------------------------------------------------------------
module interp_stage
    import filter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FACTOR = DEF_FACTOR,
    parameter int LOG2F  = $clog2(FACTOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out
);

    localparam logic [LOG2F-1:0] PHASE_LAST = LOG2F'(FACTOR - 1);

    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] cur_r;
    logic [LOG2F-1:0] phase_r;
    logic             busy_r;
    logic [WIDTH-1:0] data_out_r;
    logic             valid_out_r;

    logic             out_free_s;
    logic             last_s;
    logic             ready_in_s;
    logic             accept_s;
    logic             emit_s;
    logic [LOG2F:0]   k_s;
    logic [WIDTH-1:0] lerp_s;

    // Handshake decode. ready_in depends only on state and ready_out, so the
    // stage can take a new sample in the same cycle it emits its last phase.
    always_comb begin
        out_free_s = !valid_out_r || ready_out;
        last_s     = busy_r && (phase_r == PHASE_LAST);
        ready_in_s = !busy_r || (last_s && out_free_s);
        accept_s   = valid_in && ready_in_s;
        emit_s     = busy_r && out_free_s;
        k_s        = {1'b0, phase_r} + (LOG2F+1)'(1);
    end

    interp_lerp #(
        .WIDTH  (WIDTH),
        .FACTOR (FACTOR),
        .LOG2F  (LOG2F)
    ) u_lerp (
        .prev_s (prev_r),
        .cur_s  (cur_r),
        .k_s    (k_s),
        .lerp_s (lerp_s)
    );

    // Sample pair, phase counter and busy flag. An accept on the last phase
    // takes priority over clearing busy; the emit in that cycle still sees
    // the old pair because the lerp input is the pre-edge register value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= {WIDTH{1'b0}};
            cur_r   <= {WIDTH{1'b0}};
            phase_r <= {LOG2F{1'b0}};
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            prev_r  <= cur_r;
            cur_r   <= data_in;
            phase_r <= {LOG2F{1'b0}};
            busy_r  <= 1'b1;
        end else if (emit_s) begin
            if (phase_r != PHASE_LAST) begin
                phase_r <= phase_r + LOG2F'(1);
            end else begin
                busy_r  <= 1'b0;
            end
        end else begin
            phase_r <= phase_r;
            busy_r  <= busy_r;
        end
    end

    // Output register: load on emit, drop valid when idle and free, hold
    // both data and valid while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r  <= {WIDTH{1'b0}};
            valid_out_r <= 1'b0;
        end else if (emit_s) begin
            data_out_r  <= lerp_s;
            valid_out_r <= 1'b1;
        end else if (out_free_s) begin
            data_out_r  <= data_out_r;
            valid_out_r <= 1'b0;
        end else begin
            data_out_r  <= data_out_r;
            valid_out_r <= valid_out_r;
        end
    end

    assign ready_in  = ready_in_s;
    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;

endmodule

// File: tb/tb_interp_stage.sv
// ---------------------------------------------------------------------------
// tb_interp_stage
// Scoreboard bench for interp_stage: every accepted input pushes its FACTOR
// expected outputs (from the straight-line interpolation formula) into a
// queue; a monitor pops and compares on every output transfer. Directed
// sequences additionally compare the logged outputs against fixed values.
// ---------------------------------------------------------------------------
module tb_interp_stage;

    localparam int WIDTH  = 16;
    localparam int FACTOR = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] data_in = 16'd0;
    logic             valid_in = 1'b0;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_out = 1'b1;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     exp_q[$];
    int     log_q[$];
    int     log_cyc[$];
    longint m_prev = 0;
    logic   hold_pend = 1'b0;
    logic [WIDTH-1:0] hold_data = 16'd0;

    interp_stage #(.WIDTH(WIDTH), .FACTOR(FACTOR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (valid_in && ready_in) begin
                    for (int k = 1; k <= FACTOR; k++) begin
                        exp_q.push_back(int'((m_prev * (FACTOR - k) + longint'(data_in) * k) / FACTOR));
                    end
                    m_prev = longint'(data_in);
                end
                if (hold_pend) begin
                    chk("hold_valid", valid_out, 1);
                    chk("hold_data", data_out, hold_data);
                end
                hold_pend = valid_out && !ready_out;
                hold_data = data_out;
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_output", exp_q.size(), 1);
                    end else begin
                        chk("sample", data_out, exp_q.pop_front());
                        log_q.push_back(int'(data_out));
                        log_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Called at posedge+#1; asserts reset, checks the cleared outputs,
    // releases one cycle later.
    task automatic do_reset();
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        #1;
        chk("reset_data_out", data_out, 0);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_ready_in", ready_in, 1);
        exp_q.delete();
        log_q.delete();
        log_cyc.delete();
        m_prev    = 0;
        hold_pend = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present x until accepted; returns at posedge+#1 of the accept edge.
    task automatic send(input logic [WIDTH-1:0] x);
        logic acc;
        acc      = 1'b0;
        valid_in = 1'b1;
        data_in  = x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_in) begin
                acc = 1'b1;
                break;
            end
        end
        chk("send_accept", acc, 1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done      = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !valid_out) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic expect_log(input string name, input int exp[$]);
        chk({name, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
            chk(name, log_q[i], exp[i]);
        end
    endtask

    task automatic check_contig(input string name);
        for (int i = 1; i < log_cyc.size(); i++) begin
            chk(name, log_cyc[i] - log_cyc[i-1], 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        logic [WIDTH-1:0] r;

        @(posedge clk);
        #1;

        // Single input ramps up from zero.
        do_reset();
        send(16'd100);
        drain();
        q = '{25, 50, 75, 100};
        expect_log("ramp100", q);
        check_contig("ramp100_bubble");

        // Back-to-back inputs with valid held high: no bubbles.
        do_reset();
        send(16'd100);
        send(16'd200);
        send(16'd0);
        drain();
        q = '{25, 50, 75, 100, 125, 150, 175, 200, 150, 100, 50, 0};
        expect_log("b2b", q);
        check_contig("b2b_bubble");

        // Truncation and full scale.
        do_reset();
        send(16'd3);
        drain();
        q = '{0, 1, 2, 3};
        expect_log("trunc", q);

        do_reset();
        send(16'hFFFF);
        drain();
        q = '{16383, 32767, 49151, 65535};
        expect_log("fullscale", q);

        // Backpressure: stall three cycles while 125 is presented.
        do_reset();
        send(16'd100);
        send(16'd200);
        @(posedge clk);
        #1;
        chk("bp_first", data_out, 125);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", data_out, 125);
            chk("bp_valid", valid_out, 1);
            chk("bp_ready_in", ready_in, 0);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        drain();
        q = '{25, 50, 75, 100, 125, 150, 175, 200};
        expect_log("bp", q);

        // Reset mid-burst right after 150 is presented.
        do_reset();
        send(16'd100);
        send(16'd200);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_pre_reset", data_out, 150);
        do_reset();
        send(16'd40);
        drain();
        q = '{10, 20, 30, 40};
        expect_log("post_reset", q);

        // Randomized traffic with random backpressure and occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            case ($urandom_range(0, 3))
                0:       r = 16'h0000;
                1:       r = 16'hFFFF;
                default: r = WIDTH'($urandom);
            endcase
            valid_in  = ($urandom_range(0, 3) != 0);
            data_in   = r;
            ready_out = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
